// File: rtl/present_dec_core.sv
// present_dec_core: iterative PRESENT-80 decryption, one round per clock.
// A request first walks the key schedule forward to K32 (KEYEXP), applies the
// K32 whitening, then runs the 31 inverse rounds while stepping the key back
// down to K1 (DEC).
// Optional feature: define PRESENT_DEC_KEYCACHE_EN to remember the last user
// key and its K32, so that a repeated key skips the forward key walk.
// Handshake: start is taken on a rising edge only while busy==0. busy is high
// from the accepting edge until the edge that raises done. done is a one-cycle
// pulse, and plaintext holds its value until the next done.
module present_dec_core #(
    parameter int ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] ciphertext,
    input  logic [79:0] key,
    output logic        busy,
    output logic        done,
    output logic [63:0] plaintext,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        DEC    = 2'd2
    } fsm_t;

    localparam logic [4:0]  LAST   = 5'(ROUNDS);
    // S-box tables: nibble x of each constant holds S[x] (or Sinv[x]).
    localparam logic [63:0] S_TAB  = 64'h21748FE3DA09B65C;
    localparam logic [63:0] SI_TAB = 64'hA970364BD21C8FE5;

    fsm_t        fsm, fsm_nxt;
    logic [63:0] dstate, dstate_nxt;
    logic [79:0] kreg, kreg_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic        busy_nxt, done_nxt;
    logic [63:0] pt_nxt;
    logic [79:0] kexp, kdec;

`ifdef PRESENT_DEC_KEYCACHE_EN
    logic [79:0] cache_key, cache_key_nxt;
    logic [79:0] cache_k32, cache_k32_nxt;
    logic        cache_vld, cache_vld_nxt;
`endif

    // Forward key schedule step: K(i) -> K(i+1).
    function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = S_TAB[{r[79:76], 2'b00} +: 4];
        r[19:15]   = r[19:15] ^ i;
        return r;
    endfunction

    // Reverse key schedule step: K(i+1) -> K(i).
    function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] r;
        r          = k;
        r[19:15]   = r[19:15] ^ i;
        r[79:76]   = SI_TAB[{r[79:76], 2'b00} +: 4];
        r          = {r[60:0], r[79:61]};
        return r;
    endfunction

    // Inverse permutation followed by the inverse S-box layer.
    function automatic logic [63:0] inv_layers(input logic [63:0] s);
        logic [63:0] p, q;
        for (int b = 0; b < 63; b++) begin
            p[6'(b)] = s[6'((16 * b) % 63)];
        end
        p[63] = s[63];
        for (int n = 0; n < 16; n++) begin
            q[6'(4 * n) +: 4] = SI_TAB[{p[6'(4 * n) +: 4], 2'b00} +: 4];
        end
        return q;
    endfunction

    assign kexp      = key_upd(kreg, cnt);
    assign kdec      = key_inv(kreg, cnt);
    assign dbg_state = fsm;

    // Next-state and datapath decode; every register holds unless its phase updates it.
    always_comb begin
        fsm_nxt    = fsm;
        dstate_nxt = dstate;
        kreg_nxt   = kreg;
        cnt_nxt    = cnt;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        pt_nxt     = plaintext;
`ifdef PRESENT_DEC_KEYCACHE_EN
        cache_key_nxt = cache_key;
        cache_k32_nxt = cache_k32;
        cache_vld_nxt = cache_vld;
`endif
        case (fsm)
            IDLE: begin
                if (start) begin
                    busy_nxt = 1'b1;
`ifdef PRESENT_DEC_KEYCACHE_EN
                    if (cache_vld && (key == cache_key)) begin
                        dstate_nxt = ciphertext ^ cache_k32[79:16];
                        kreg_nxt   = cache_k32;
                        cnt_nxt    = LAST;
                        fsm_nxt    = DEC;
                    end else begin
                        // The key is remembered now and marked valid only once
                        // its K32 exists, so an aborted run never leaves a bad pair.
                        dstate_nxt    = ciphertext;
                        kreg_nxt      = key;
                        cnt_nxt       = 5'd1;
                        fsm_nxt       = KEYEXP;
                        cache_key_nxt = key;
                        cache_vld_nxt = 1'b0;
                    end
`else
                    dstate_nxt = ciphertext;
                    kreg_nxt   = key;
                    cnt_nxt    = 5'd1;
                    fsm_nxt    = KEYEXP;
`endif
                end
            end
            KEYEXP: begin
                kreg_nxt = kexp;
                if (cnt == LAST) begin
                    dstate_nxt = dstate ^ kexp[79:16];
                    fsm_nxt    = DEC;
`ifdef PRESENT_DEC_KEYCACHE_EN
                    cache_k32_nxt = kexp;
                    cache_vld_nxt = 1'b1;
`endif
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            DEC: begin
                dstate_nxt = inv_layers(dstate) ^ kdec[79:16];
                kreg_nxt   = kdec;
                cnt_nxt    = cnt - 5'd1;
                if (cnt == 5'd1) begin
                    pt_nxt   = dstate_nxt;
                    done_nxt = 1'b1;
                    busy_nxt = 1'b0;
                    fsm_nxt  = IDLE;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    // State, datapath and output registers; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            dstate    <= '0;
            kreg      <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            plaintext <= '0;
`ifdef PRESENT_DEC_KEYCACHE_EN
            cache_key <= '0;
            cache_k32 <= '0;
            cache_vld <= 1'b0;
`endif
        end else begin
            fsm       <= fsm_nxt;
            dstate    <= dstate_nxt;
            kreg      <= kreg_nxt;
            cnt       <= cnt_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            plaintext <= pt_nxt;
`ifdef PRESENT_DEC_KEYCACHE_EN
            cache_key <= cache_key_nxt;
            cache_k32 <= cache_k32_nxt;
            cache_vld <= cache_vld_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_present_dec_core.sv
// tb_present_dec_core: known-answer vectors plus random round trips through a
// behavioural PRESENT-80 encryption model; latency comes from a small cache model.
module tb_present_dec_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] ciphertext;
    logic [79:0] key;
    logic        busy;
    logic        done;
    logic [63:0] plaintext;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    logic [63:0] last_pt;
    bit          m_cvld;
    logic [79:0] m_ckey;

    localparam logic [79:0] KF  = {80{1'b1}};
    localparam logic [63:0] PTF = {64{1'b1}};
    localparam logic [63:0] CT1 = 64'h5579C1387B228445;
    localparam logic [63:0] CT2 = 64'hE72C46C0F5945049;

    int sb[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    present_dec_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ciphertext (ciphertext),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .plaintext  (plaintext),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: textbook PRESENT-80 encryption.
    function automatic logic [63:0] enc(input logic [63:0] pt, input logic [79:0] k);
        logic [79:0] kk;
        logic [63:0] s, t;
        kk = k;
        s  = pt;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ kk[79:16];
            for (int n = 0; n < 16; n++) s[n*4 +: 4] = 4'(sb[s[n*4 +: 4]]);
            t = '0;
            for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (b * 16) % 63] = s[b];
            s  = t;
            kk = (kk << 61) | (kk >> 19);
            kk[79:76] = 4'(sb[kk[79:76]]);
            kk[19:15] = kk[19:15] ^ 5'(r);
        end
        return s ^ kk[79:16];
    endfunction

    // Driver: one request, timed from the accepting edge to done.
    task automatic do_op(input logic [63:0] ct, input logic [79:0] k, input logic [63:0] pt_exp,
                         input string tag, input int poke_at, input int abort_at);
        int n;
        int lat;
        int busy_bad;
        bit hit;
        hit = 1'b0;
`ifdef PRESENT_DEC_KEYCACHE_EN
        hit = m_cvld && (k == m_ckey);
`endif
        lat = hit ? 31 : 62;
        @(negedge clk);
        ciphertext = ct;
        key        = k;
        start      = 1'b1;
        exp_q.push_back(pt_exp);
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        ciphertext = ~ct;
        key        = ~k;
        check({tag, ".busy_on"}, 80'(busy), 80'(1));
        check({tag, ".pt_hold"}, 80'(plaintext), 80'(last_pt));
        n = 0;
        busy_bad = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            start = (n == poke_at);
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, ".abort_busy"}, 80'(busy), 80'(0));
                check({tag, ".abort_done"}, 80'(done), 80'(0));
                check({tag, ".abort_pt"}, 80'(plaintext), 80'(0));
                check({tag, ".abort_fsm"}, 80'(dbg_state), 80'(0));
                exp_q.delete();
                m_cvld  = 1'b0;
                last_pt = '0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (done !== 1'b1 && busy !== 1'b1) busy_bad++;
        end
        check({tag, ".latency"}, 80'(n), 80'(lat));
        check({tag, ".busy_hold"}, 80'(busy_bad), 80'(0));
        check({tag, ".busy_off"}, 80'(busy), 80'(0));
        if (exp_q.size() > 0) check({tag, ".pt"}, 80'(plaintext), 80'(exp_q.pop_front()));
        last_pt = pt_exp;
        m_cvld  = 1'b1;
        m_ckey  = k;
        @(negedge clk);
        check({tag, ".done_pulse"}, 80'(done), 80'(0));
    endtask

    // Driver: start held high across two requests with the same key.
    task automatic b2b();
        int n;
        int gap;
        @(negedge clk);
        ciphertext = CT1;
        key        = '0;
        start      = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b.pt1", 80'(plaintext), 80'(0));
        m_cvld = 1'b1;
        m_ckey = '0;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (done !== 1'b1 && gap < 200);
        start = 1'b0;
`ifdef PRESENT_DEC_KEYCACHE_EN
        check("b2b.gap", 80'(gap), 80'(32));
`else
        check("b2b.gap", 80'(gap), 80'(63));
`endif
        check("b2b.pt2", 80'(plaintext), 80'(0));
        last_pt = '0;
        @(negedge clk);
        check("b2b.idle", 80'(busy), 80'(0));
    endtask

    // Stimulus and final report.
    initial begin
        logic [79:0] rk;
        logic [63:0] rpt;
        logic [95:0] tmp;
        rst_n      = 1'b0;
        start      = 1'b0;
        ciphertext = '0;
        key        = '0;
        last_pt    = '0;
        m_cvld     = 1'b0;
        m_ckey     = '0;
        rk         = '0;
        repeat (3) @(negedge clk);
        check("rst.busy", 80'(busy), 80'(0));
        check("rst.done", 80'(done), 80'(0));
        check("rst.pt", 80'(plaintext), 80'(0));
        check("rst.fsm", 80'(dbg_state), 80'(0));
        rst_n = 1'b1;

        do_op(CT1, '0, '0, "t1", 0, 0);
        do_op(CT2, KF, '0, "t2", 0, 0);
        do_op(64'hA112FFC72F68417B, '0, PTF, "t3a", 0, 0);
        do_op(64'h3333DCD3213210D2, KF, PTF, "t3b", 0, 0);
        do_op(CT1, '0, '0, "t4", 10, 0);
        do_op(CT1, '0, '0, "t5", 0, 40);
        do_op(CT2, KF, '0, "t5b", 0, 0);
        do_op(CT1, '0, '0, "t6a", 0, 0);
        do_op(CT1, '0, '0, "t6b", 0, 0);
        do_op(CT2, KF, '0, "t6c", 0, 0);
        b2b();

        for (int i = 0; i < 8; i++) begin
            if (i % 3 != 2) begin
                tmp = {$urandom(), $urandom(), $urandom()};
                rk  = tmp[79:0];
            end
            rpt = {$urandom(), $urandom()};
            do_op(enc(rpt, rk), rk, rpt, "rnd", 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
